imm_extend_pipe: RTL and testbench

//  Parametrised immediate generator for the ARC MIPS decode stage; successor to the single-mode extender.

---
 rtl/arc_pkg.sv | 22 ++
 rtl/imm_extend_core.sv | 57 +++++
 rtl/imm_extend_pipe.sv | 119 +++++++++++
 tb/tb_imm_extend_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arc_pkg.sv
// Shared definitions for the ARC MIPS decode-stage immediate path.
// Contents:
//   OPERAND_W      default datapath operand width
//   imm_mode_e     immediate extension mode encodings (3 bits, 5..7 illegal)
//   mode_is_legal  helper returning 1 for an encoding the extender implements
package arc_pkg;

   localparam int OPERAND_W = 32;

   typedef enum logic [2:0] {
      IMM_SIGN   = 3'd0,
      IMM_ZERO   = 3'd1,
      IMM_LUI    = 3'd2,
      IMM_BRANCH = 3'd3,
      IMM_JUMP   = 3'd4
   } imm_mode_e;

   function automatic logic mode_is_legal(input logic [2:0] mode);
      return (mode <= 3'd4);
   endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: picks the immediate or jump field out of an
// instruction word and forms an OUT_W-bit operand according to the mode.
// Ports:
//   instr  in   INSTR_W  instruction word
//   mode   in   3        extension mode (arc_pkg::imm_mode_e encodings)
//   data   out  OUT_W    extended operand, 0 for an illegal mode
//   err    out  1        1 when mode is not a legal encoding
module imm_extend_core
   import arc_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int IMM_W   = 16,
   parameter int JMP_W   = 26,
   parameter int OUT_W   = OPERAND_W
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [2:0]         mode,
   output logic [OUT_W-1:0]   data,
   output logic               err
);

   logic [IMM_W-1:0] imm_s;
   logic [JMP_W-1:0] jmp_s;
   logic [OUT_W-1:0] sext_s;
   logic [OUT_W-1:0] zext_s;
   logic [OUT_W-1:0] jext_s;

   assign imm_s  = instr[IMM_W-1:0];
   assign jmp_s  = instr[JMP_W-1:0];
   assign sext_s = {{(OUT_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
   assign zext_s = {{(OUT_W-IMM_W){1'b0}}, imm_s};
   assign jext_s = {{(OUT_W-JMP_W){1'b0}}, jmp_s};

   // Opcode bits above the jump field play no part in the immediate.
   if (INSTR_W > JMP_W) begin : g_spare
      logic unused_bits_s;
      assign unused_bits_s = ^instr[INSTR_W-1:JMP_W];
   end

   // Mode select; shifts truncate to OUT_W by construction of the operands.
   always_comb begin
      data = {OUT_W{1'b0}};
      err  = 1'b0;
      case (mode)
         IMM_SIGN:   data = sext_s;
         IMM_ZERO:   data = zext_s;
         IMM_LUI:    data = zext_s << IMM_W;
         IMM_BRANCH: data = sext_s << 2'd2;
         IMM_JUMP:   data = jext_s << 2'd2;
         default: begin
            data = {OUT_W{1'b0}};
            err  = ~mode_is_legal(mode);
         end
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate generator with a PIPE_DEPTH-deep valid/ready pipeline, stall and flush.
// Sits between fetch/decode and the ID/EX register.
// Ports:
//   clock       in   1        rising-edge clock
//   reset_n     in   1        asynchronous active-low reset
//   i_valid     in   1        input item present
//   o_ready     out  1        item accepted this cycle when i_valid is also 1
//   i_instr     in   INSTR_W  instruction word
//   i_mode      in   3        extension mode
//   i_flush     in   1        discard all in-flight items at the next edge
//   o_valid     out  1        o_data_imm / o_mode_err hold a result
//   i_ready     in   1        downstream consumes the result this cycle
//   o_data_imm  out  OUT_W    extended immediate
//   o_mode_err  out  1        result came from an illegal mode
module imm_extend_pipe
   import arc_pkg::*;
#(
   parameter int INSTR_W    = 32,
   parameter int IMM_W      = 16,
   parameter int JMP_W      = 26,
   parameter int OUT_W      = OPERAND_W,
   parameter int PIPE_DEPTH = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [2:0]         i_mode,
   input  logic               i_flush,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [OUT_W-1:0]   o_data_imm,
   output logic               o_mode_err
);

   if (OUT_W < JMP_W + 2 || OUT_W < IMM_W + 2 || PIPE_DEPTH < 1 || PIPE_DEPTH > 4 ||
       IMM_W > JMP_W || JMP_W > INSTR_W) begin : g_param_check
      $error("imm_extend_pipe: illegal parameter combination");
   end

   logic [OUT_W-1:0]      core_data_s;
   logic                  core_err_s;
   logic                  accept_s;
   logic [PIPE_DEPTH-1:0] valid_s;
   logic [PIPE_DEPTH-1:0] err_s;
   logic [PIPE_DEPTH-1:0] adv_s;
   logic [OUT_W-1:0]      data_s [PIPE_DEPTH];

   imm_extend_core #(
      .INSTR_W (INSTR_W),
      .IMM_W   (IMM_W),
      .JMP_W   (JMP_W),
      .OUT_W   (OUT_W)
   ) u_core (
      .instr (i_instr),
      .mode  (i_mode),
      .data  (core_data_s),
      .err   (core_err_s)
   );

   assign o_ready  = adv_s[0] & ~i_flush;
   assign accept_s = i_valid & o_ready;

   for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
      logic             prev_valid_s;
      logic [OUT_W-1:0] prev_data_s;
      logic             prev_err_s;
      logic             valid_r;
      logic [OUT_W-1:0] data_r;
      logic             err_r;

      if (k == 0) begin : g_first
         assign prev_valid_s = accept_s;
         assign prev_data_s  = core_data_s;
         assign prev_err_s   = core_err_s;
      end else begin : g_next
         assign prev_valid_s = valid_s[k-1];
         assign prev_data_s  = data_s[k-1];
         assign prev_err_s   = err_s[k-1];
      end

      // A stage can move on unless it and every stage after it are full and the
      // output is stalled; this is the unrolled adv_k = !valid_k || adv_{k+1}.
      assign adv_s[k]   = i_ready | ~(&valid_s[PIPE_DEPTH-1:k]);
      assign valid_s[k] = valid_r;
      assign data_s[k]  = data_r;
      assign err_s[k]   = err_r;

      // Stage register: flush drops validity; payload only moves with a valid item.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= {OUT_W{1'b0}};
            err_r   <= 1'b0;
         end else begin
            if (i_flush) begin
               valid_r <= 1'b0;
            end else if (adv_s[k]) begin
               valid_r <= prev_valid_s;
            end else begin
               valid_r <= valid_r;
            end
            if (adv_s[k] && prev_valid_s) begin
               data_r <= prev_data_s;
               err_r  <= prev_err_s;
            end else begin
               data_r <= data_r;
               err_r  <= err_r;
            end
         end
      end
   end

   assign o_valid    = valid_s[PIPE_DEPTH-1];
   assign o_data_imm = data_s[PIPE_DEPTH-1];
   assign o_mode_err = err_s[PIPE_DEPTH-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [2:0]  i_mode;
   logic        i_flush;
   logic        i_ready;

   logic        d1_ready, d1_valid, d1_err;
   logic [31:0] d1_data;
   logic        d3_ready, d3_valid, d3_err;
   logic [31:0] d3_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   imm_extend_pipe #(.PIPE_DEPTH(1)) u_d1 (
      .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(d1_ready),
      .i_instr(i_instr), .i_mode(i_mode), .i_flush(i_flush), .o_valid(d1_valid),
      .i_ready(i_ready), .o_data_imm(d1_data), .o_mode_err(d1_err)
   );

   imm_extend_pipe #(.PIPE_DEPTH(3)) u_d3 (
      .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(d3_ready),
      .i_instr(i_instr), .i_mode(i_mode), .i_flush(i_flush), .o_valid(d3_valid),
      .i_ready(i_ready), .o_data_imm(d3_data), .o_mode_err(d3_err)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  mode;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [2:0] mode);
      i_valid = 1'b1;
      i_instr = instr;
      i_mode  = mode;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time 200000 exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h0000_8004, 3'd0, 32'hFFFF_8004, 1'b0};
      vecs[1]  = '{32'h03FF_8001, 3'd1, 32'h0000_8001, 1'b0};
      vecs[2]  = '{32'h03FF_8001, 3'd2, 32'h8001_0000, 1'b0};
      vecs[3]  = '{32'h03FF_8001, 3'd3, 32'hFFFE_0004, 1'b0};
      vecs[4]  = '{32'h03FF_8001, 3'd4, 32'h0FFE_0004, 1'b0};
      vecs[5]  = '{32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1'b1};
      vecs[6]  = '{32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFF, 1'b0};
      vecs[7]  = '{32'h1234_5678, 3'd5, 32'h0000_0000, 1'b1};
      vecs[8]  = '{32'h0000_FFFF, 3'd7, 32'h0000_0000, 1'b1};
      vecs[9]  = '{32'h0000_7FFF, 3'd0, 32'h0000_7FFF, 1'b0};
      vecs[10] = '{32'h0000_FFFF, 3'd2, 32'hFFFF_0000, 1'b0};
      vecs[11] = '{32'h0000_7FFF, 3'd3, 32'h0001_FFFC, 1'b0};
      vecs[12] = '{32'hFFFF_FFFF, 3'd4, 32'h0FFF_FFFC, 1'b0};
      vecs[13] = '{32'hABCD_FFFF, 3'd1, 32'h0000_FFFF, 1'b0};

      reset_n = 1'b0;
      i_valid = 1'b0;
      i_instr = 32'h0;
      i_mode  = 3'd0;
      i_flush = 1'b0;
      i_ready = 1'b1;

      // reset state
      #12;
      chk("rst_d1_valid", {31'h0, d1_valid}, 32'h0);
      chk("rst_d1_data", d1_data, 32'h0);
      chk("rst_d1_err", {31'h0, d1_err}, 32'h0);
      chk("rst_d1_ready", {31'h0, d1_ready}, 32'h1);
      chk("rst_d3_valid", {31'h0, d3_valid}, 32'h0);
      chk("rst_d3_ready", {31'h0, d3_ready}, 32'h1);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      chk("post_rst_d1_ready", {31'h0, d1_ready}, 32'h1);
      chk("post_rst_d1_valid", {31'h0, d1_valid}, 32'h0);

      // depth 1: one-cycle latency, back-to-back vectors
      for (int i = 0; i < 14; i++) begin
         push(vecs[i].instr, vecs[i].mode);
         tick();
         chk($sformatf("vec%0d_valid", i), {31'h0, d1_valid}, 32'h1);
         chk($sformatf("vec%0d_data", i), d1_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_err", i), {31'h0, d1_err}, {31'h0, vecs[i].exp_err});
      end
      i_valid = 1'b0;
      tick();
      chk("d1_drain_valid", {31'h0, d1_valid}, 32'h0);

      // clean restart for the depth-3 sequences
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      tick();

      // depth 3: A,B,C back to back with output stalled, then D waits
      i_ready = 1'b0;
      push(32'h0000_00A1, 3'd1);
      chk("stall_ready_a", {31'h0, d3_ready}, 32'h1);
      tick();
      push(32'h0000_00B2, 3'd1);
      chk("stall_ready_b", {31'h0, d3_ready}, 32'h1);
      chk("stall_lat_b", {31'h0, d3_valid}, 32'h0);
      tick();
      push(32'h0000_00C3, 3'd1);
      chk("stall_ready_c", {31'h0, d3_ready}, 32'h1);
      chk("stall_lat_c", {31'h0, d3_valid}, 32'h0);
      tick();
      push(32'h0000_00D4, 3'd1);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("stall%0d_valid", c), {31'h0, d3_valid}, 32'h1);
         chk($sformatf("stall%0d_data", c), d3_data, 32'h0000_00A1);
         chk($sformatf("stall%0d_ready", c), {31'h0, d3_ready}, 32'h0);
         if (c < 3) tick();
      end
      i_ready = 1'b1;
      #1;
      chk("unstall_ready", {31'h0, d3_ready}, 32'h1);
      tick();
      i_valid = 1'b0;
      chk("order_b", d3_data, 32'h0000_00B2);
      chk("order_b_valid", {31'h0, d3_valid}, 32'h1);
      tick();
      chk("order_c", d3_data, 32'h0000_00C3);
      tick();
      chk("order_d", d3_data, 32'h0000_00D4);
      chk("order_d_valid", {31'h0, d3_valid}, 32'h1);
      tick();
      chk("order_empty", {31'h0, d3_valid}, 32'h0);

      // depth 3: flush with three items in flight and an item presented
      push(32'h0000_0011, 3'd1);
      tick();
      push(32'h0000_0022, 3'd1);
      tick();
      push(32'h0000_0033, 3'd1);
      tick();
      chk("pre_flush_valid", {31'h0, d3_valid}, 32'h1);
      chk("pre_flush_data", d3_data, 32'h0000_0011);
      i_flush = 1'b1;
      push(32'h0000_0EEE, 3'd1);
      #1;
      chk("flush_ready", {31'h0, d3_ready}, 32'h0);
      tick();
      i_flush = 1'b0;
      chk("flush_valid", {31'h0, d3_valid}, 32'h0);
      push(32'h0000_0077, 3'd1);
      tick();
      i_valid = 1'b0;
      chk("post_flush_c1", {31'h0, d3_valid}, 32'h0);
      tick();
      chk("post_flush_c2", {31'h0, d3_valid}, 32'h0);
      tick();
      chk("post_flush_c3_valid", {31'h0, d3_valid}, 32'h1);
      chk("post_flush_c3_data", d3_data, 32'h0000_0077);
      tick();
      chk("post_flush_empty", {31'h0, d3_valid}, 32'h0);

      // asynchronous reset mid-stream
      push(32'h0000_8004, 3'd0);
      tick();
      tick();
      tick();
      chk("pre_rst_valid", {31'h0, d3_valid}, 32'h1);
      i_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_d3_valid", {31'h0, d3_valid}, 32'h0);
      chk("async_rst_d3_data", d3_data, 32'h0);
      chk("async_rst_d1_data", d1_data, 32'h0);
      #4;
      reset_n = 1'b1;
      #1;
      chk("rel_ready", {31'h0, d3_ready}, 32'h1);
      tick();
      chk("rel_valid", {31'h0, d3_valid}, 32'h0);
      push(32'h0000_0001, 3'd3);
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      chk("rel_item_valid", {31'h0, d3_valid}, 32'h1);
      chk("rel_item_data", d3_data, 32'h0000_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
